// File: rtl/regfile_pkg.sv
// Shared register-file types and constants used by the write arbiter,
// the register file and the write requesters.
package regfile_pkg;

   localparam int REG_ADDR_W = 2;
   localparam int REG_DATA_W = 8;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   // One write request as seen by the register file and its requesters.
   typedef struct packed {
      logic      valid;
      reg_addr_t addr;
      reg_data_t data;
   } wr_req_t;

   // Index of the requester following idx, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rr_pick: returns the first requester at or after start_i (wrapping) whose
// request and mask bits are both set.
module rr_pick #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [N-1:0]  mask_i,
   input  logic [IW-1:0] start_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   logic [N-1:0]   elig;
   logic [2*N-1:0] elig_rot;

   assign elig     = req_i & mask_i;
   // Doubling the vector lets a plain right shift act as a rotate by start_i.
   assign elig_rot = {elig, elig} >> start_i;

   // Nearest eligible bit wins; scanning far-to-near leaves the nearest hit last.
   always_comb begin
      logic [IW:0] sum;
      found_o = 1'b0;
      idx_o   = '0;
      sum     = '0;
      for (int p = N - 1; p >= 0; p--) begin
         if (elig_rot[p]) begin
            sum = {1'b0, start_i} + (IW+1)'(p);
            if (sum >= (IW+1)'(N)) begin
               sum = sum - (IW+1)'(N);
            end
            found_o = 1'b1;
            idx_o   = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register file's two write
// ports among NUM_REQ requesters, with registered port outputs and a
// pending-write mask. Optional stall counter enabled by REGARB_STALL_CNT_EN.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int DATA_W  = REG_DATA_W
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [ADDR_W-1:0]           wr1,
   output logic [ADDR_W-1:0]           wr2,
   output logic [DATA_W-1:0]           wr1_data,
   output logic [DATA_W-1:0]           wr2_data,
   output logic                        wr1_enable,
   output logic                        wr2_enable,
   output logic [(2**ADDR_W)-1:0]      wr_pending
`ifdef REGARB_STALL_CNT_EN
   ,
   output logic [15:0]                 stall_count
`endif
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NR = 2 ** ADDR_W;

   logic [ADDR_W-1:0]  addr_a [NUM_REQ];
   logic [DATA_W-1:0]  data_a [NUM_REQ];
   logic [NUM_REQ-1:0] mask2;
   logic [NUM_REQ-1:0] all_ones;

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          found1, found2;
   logic [IW-1:0] g1_idx, g2_idx;
   logic [IW-1:0] start2;
   logic          grant1, grant2;

   logic [ADDR_W-1:0] wr1_q, wr2_q;
   logic [DATA_W-1:0] wr1_data_q, wr2_data_q;
   logic              wr1_en_q, wr2_en_q;

   assign all_ones = '1;

   // Unpack the flat request buses and mark who may take the second port:
   // anyone other than grant 1 whose target register differs from it.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_a[gi] = req_addr[gi*ADDR_W +: ADDR_W];
         assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
         assign mask2[gi]  = (IW'(gi) != g1_idx) && (addr_a[gi] != addr_a[g1_idx]);
      end
   endgenerate

   rr_pick #(.N(NUM_REQ)) u_pick1 (
      .req_i   (req_valid),
      .mask_i  (all_ones),
      .start_i (rr_ptr_q),
      .found_o (found1),
      .idx_o   (g1_idx)
   );

   // Second scan continues just past grant 1, so it keeps round-robin order.
   assign start2 = IW'(wrap_inc(int'(g1_idx), NUM_REQ));

   rr_pick #(.N(NUM_REQ)) u_pick2 (
      .req_i   (req_valid),
      .mask_i  (mask2),
      .start_i (start2),
      .found_o (found2),
      .idx_o   (g2_idx)
   );

   assign grant1 = found1 & ~reset;
   assign grant2 = found1 & found2 & ~reset;

   // Grant vector and the pointer advance past the last grant of this cycle.
   always_comb begin
      req_ready = '0;
      rr_ptr_d  = rr_ptr_q;
      if (grant1) begin
         req_ready[g1_idx] = 1'b1;
         rr_ptr_d          = IW'(wrap_inc(int'(g1_idx), NUM_REQ));
      end
      if (grant2) begin
         req_ready[g2_idx] = 1'b1;
         rr_ptr_d          = IW'(wrap_inc(int'(g2_idx), NUM_REQ));
      end
   end

   // Register granted writes onto the ports; idle ports keep their last addr/data.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         wr1_q      <= '0;
         wr2_q      <= '0;
         wr1_data_q <= '0;
         wr2_data_q <= '0;
         wr1_en_q   <= 1'b0;
         wr2_en_q   <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         wr1_en_q <= grant1;
         wr2_en_q <= grant2;
         if (grant1) begin
            wr1_q      <= addr_a[g1_idx];
            wr1_data_q <= data_a[g1_idx];
         end
         if (grant2) begin
            wr2_q      <= addr_a[g2_idx];
            wr2_data_q <= data_a[g2_idx];
         end
      end
   end

   // Registers with a write currently on either port.
   always_comb begin
      wr_pending = '0;
      if (wr1_en_q) wr_pending[wr1_q] = 1'b1;
      if (wr2_en_q) wr_pending[wr2_q] = 1'b1;
   end

   assign wr1        = wr1_q;
   assign wr2        = wr2_q;
   assign wr1_data   = wr1_data_q;
   assign wr2_data   = wr2_data_q;
   assign wr1_enable = wr1_en_q;
   assign wr2_enable = wr2_en_q;

`ifdef REGARB_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        any_stall;

   assign any_stall = |(req_valid & ~req_ready);

   // Count cycles where some valid requester was left waiting, saturating.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (any_stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Stall counter register, cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule
